// File: rtl/bch_encoder_serial_if.sv
// Handshake bundle for the serial BCH encoder: message input, codeword output, frame control.
// Optional SOF/EOF flags are present only with BCH_FRAME_FLAGS_EN.
interface bch_encoder_serial_if;
   logic init;
   logic din;
   logic din_valid;
   logic din_ready;
   logic dout;
   logic dout_valid;
   logic dout_ready;
   logic parity_phase;
   logic busy;
`ifdef BCH_FRAME_FLAGS_EN
   logic dout_sof;
   logic dout_eof;
`endif

   modport master (
      output init, din, din_valid, dout_ready,
`ifdef BCH_FRAME_FLAGS_EN
      input  dout_sof, dout_eof,
`endif
      input  din_ready, dout, dout_valid, parity_phase, busy
   );

   modport slave (
      input  init, din, din_valid, dout_ready,
`ifdef BCH_FRAME_FLAGS_EN
      output dout_sof, dout_eof,
`endif
      output din_ready, dout, dout_valid, parity_phase, busy
   );
endinterface

// File: rtl/bch_encoder_serial.sv
// Bit-serial systematic (N,K) BCH encoder: K message bits pass through, then N-K parity bits.
// Define BCH_FRAME_FLAGS_EN to add registered dout_sof/dout_eof frame markers.
module bch_encoder_serial #(
   parameter int unsigned N                = 15,
   parameter int unsigned K                = 7,
   parameter logic [N-K:0] GEN_POLY        = 9'h1D1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   bch_encoder_serial_if.slave   bus
);
   localparam int unsigned P = N - K;

   if (GEN_POLY[P] == 1'b0 || GEN_POLY[0] == 1'b0 || K >= N) begin : g_param_check
      $error("bch_encoder_serial: illegal N/K/GEN_POLY combination");
   end

   typedef enum logic {StData, StParity} state_e;

   state_e         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [P-1:0]   lfsr_q, lfsr_d;
   logic           dout_q, dout_d;
   logic           dout_valid_q, dout_valid_d;
   logic           parity_phase_q, parity_phase_d;
`ifdef BCH_FRAME_FLAGS_EN
   logic           sof_q, sof_d;
   logic           eof_q, eof_d;
`endif

   logic slot;
   logic din_ready;
   logic accept;
   logic fb;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lfsr_d         = lfsr_q;
      dout_d         = dout_q;
      dout_valid_d   = dout_valid_q;
      parity_phase_d = parity_phase_q;
`ifdef BCH_FRAME_FLAGS_EN
      sof_d          = sof_q;
      eof_d          = eof_q;
`endif
      // Output register may load when empty or when its bit is consumed this edge.
      slot      = !dout_valid_q || bus.dout_ready;
      din_ready = (state_q == StData) && slot && !bus.init;
      accept    = bus.din_valid && din_ready;
      fb        = bus.din ^ lfsr_q[P-1];

      if (bus.init) begin
         state_d        = StData;
         cnt_d          = '0;
         lfsr_d         = '0;
         dout_valid_d   = 1'b0;
         parity_phase_d = 1'b0;
`ifdef BCH_FRAME_FLAGS_EN
         sof_d          = 1'b0;
         eof_d          = 1'b0;
`endif
      end else if (slot) begin
         unique case (state_q)
            StData: begin
               if (accept) begin
                  dout_d         = bus.din;
                  dout_valid_d   = 1'b1;
                  parity_phase_d = 1'b0;
                  lfsr_d         = (lfsr_q << 1) ^ (fb ? GEN_POLY[P-1:0] : '0);
`ifdef BCH_FRAME_FLAGS_EN
                  sof_d          = (cnt_q == 8'd0);
                  eof_d          = 1'b0;
`endif
                  if (cnt_q == 8'(K - 1)) begin
                     cnt_d   = '0;
                     state_d = StParity;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  dout_valid_d = 1'b0;
               end
            end
            StParity: begin
               dout_d         = lfsr_q[P-1];
               dout_valid_d   = 1'b1;
               parity_phase_d = 1'b1;
               lfsr_d         = lfsr_q << 1;
`ifdef BCH_FRAME_FLAGS_EN
               sof_d          = 1'b0;
               eof_d          = (cnt_q == 8'(P - 1));
`endif
               if (cnt_q == 8'(P - 1)) begin
                  cnt_d   = '0;
                  state_d = StData;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = StData;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StData;
         cnt_q          <= '0;
         lfsr_q         <= '0;
         dout_q         <= 1'b0;
         dout_valid_q   <= 1'b0;
         parity_phase_q <= 1'b0;
`ifdef BCH_FRAME_FLAGS_EN
         sof_q          <= 1'b0;
         eof_q          <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lfsr_q         <= lfsr_d;
         dout_q         <= dout_d;
         dout_valid_q   <= dout_valid_d;
         parity_phase_q <= parity_phase_d;
`ifdef BCH_FRAME_FLAGS_EN
         sof_q          <= sof_d;
         eof_q          <= eof_d;
`endif
      end
   end

   assign bus.din_ready    = din_ready;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.parity_phase = parity_phase_q;
   assign bus.busy         = (cnt_q != 8'd0) || dout_valid_q;
`ifdef BCH_FRAME_FLAGS_EN
   assign bus.dout_sof     = sof_q;
   assign bus.dout_eof     = eof_q;
`endif
endmodule

// File: tb/tb_bch_encoder_serial.sv
// Directed self-checking bench for bch_encoder_serial with the default (15,7) code.
// Frame flags are checked when BCH_FRAME_FLAGS_EN is defined.
module tb_bch_encoder_serial;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   cyc;

   bch_encoder_serial_if bus ();

   bch_encoder_serial #(
      .N        (15),
      .K        (7),
      .GEN_POLY (9'h1D1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic q_bit[$];
   logic q_pp[$];
   int   q_cyc[$];
   logic q_sof[$];
   logic q_eof[$];

   // Record every bit the sink accepts; the transfer completes at the following rising edge.
   always @(negedge clk) begin
      if (reset_n && bus.dout_valid && bus.dout_ready) begin
         q_bit.push_back(bus.dout);
         q_pp.push_back(bus.parity_phase);
         q_cyc.push_back(cyc);
`ifdef BCH_FRAME_FLAGS_EN
         q_sof.push_back(bus.dout_sof);
         q_eof.push_back(bus.dout_eof);
`else
         q_sof.push_back(1'b0);
         q_eof.push_back(1'b0);
`endif
      end
   end

   function automatic logic [31:0] pack(input logic qq[$]);
      logic [31:0] v = '0;
      foreach (qq[i]) v = {v[30:0], qq[i]};
      return v;
   endfunction

   task automatic clear_q();
      q_bit.delete();
      q_pp.delete();
      q_cyc.delete();
      q_sof.delete();
      q_eof.delete();
   endtask

   task automatic send_bits(input logic [14:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         int  b;
         logic acc;
         b = 0;
         bus.din       = bits[nbits-1-i];
         bus.din_valid = 1'b1;
         do begin
            @(negedge clk);
            acc = bus.din_ready;
            @(posedge clk);
            #1;
            b++;
         end while (!acc && b < 100);
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: bit %0d not accepted, din_ready=%b required 1", i,
                     bus.din_ready);
         end
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int b;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (bus.busy && b < 200);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: busy=%b required 0", name, bus.busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_size(input int n);
      int b;
      b = 0;
      while (q_bit.size() < n && b < 200) begin
         @(posedge clk);
         #2;
         b++;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({bus.dout, bus.dout_valid, bus.parity_phase, bus.busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: dout/valid/pp/busy=%b required 0000",
                  {bus.dout, bus.dout_valid, bus.parity_phase, bus.busy});
      end
`ifdef BCH_FRAME_FLAGS_EN
      checks++;
      if ({bus.dout_sof, bus.dout_eof} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: sof/eof=%b required 00", {bus.dout_sof, bus.dout_eof});
      end
`endif
      #8;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.din_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_din_ready: din_ready=%b required 1", bus.din_ready);
      end
   endtask

   task automatic test_all_zero();
      clear_q();
      send_bits(15'b0000000, 7);
      wait_idle("all_zero");
      checks++;
      if (q_bit.size() !== 15 || pack(q_bit) !== 32'h0) begin
         errors++;
         $display("FAIL all_zero_codeword: n=%0d bits=%h required n=15 bits=0000",
                  q_bit.size(), pack(q_bit));
      end
      checks++;
      if (pack(q_pp) !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL all_zero_parity_phase: got %h required 000000ff", pack(q_pp));
      end
   endtask

   task automatic test_single_one(input string name);
      clear_q();
      send_bits(15'b1000000, 7);
      wait_idle(name);
      checks++;
      if (q_bit.size() !== 15 || pack(q_bit) !== 32'h0000_40E8) begin
         errors++;
         $display("FAIL %s_codeword: n=%0d bits=%h required n=15 bits=000040e8", name,
                  q_bit.size(), pack(q_bit));
      end
      checks++;
      if (q_cyc.size() == 15 && q_cyc[14] - q_cyc[0] !== 14) begin
         errors++;
         $display("FAIL %s_span: %0d cycles required 14", name, q_cyc[14] - q_cyc[0]);
      end
`ifdef BCH_FRAME_FLAGS_EN
      checks++;
      if (pack(q_sof) !== 32'h0000_4000 || pack(q_eof) !== 32'h0000_0001) begin
         errors++;
         $display("FAIL %s_flags: sof=%h eof=%h required 00004000 00000001", name,
                  pack(q_sof), pack(q_eof));
      end
`endif
   endtask

   task automatic test_back_to_back();
      clear_q();
      send_bits(15'b1111111, 7);
      send_bits(15'b1111111, 7);
      wait_idle("back_to_back");
      checks++;
      if (q_bit.size() !== 30 || pack(q_bit) !== 32'h3FFF_FFFF) begin
         errors++;
         $display("FAIL b2b_codewords: n=%0d bits=%h required n=30 bits=3fffffff",
                  q_bit.size(), pack(q_bit));
      end
      checks++;
      if (q_cyc.size() == 30 && q_cyc[29] - q_cyc[0] !== 29) begin
         errors++;
         $display("FAIL b2b_no_gap: span %0d cycles required 29", q_cyc[29] - q_cyc[0]);
      end
   endtask

   task automatic test_backpressure();
      clear_q();
      fork
         send_bits(15'b1000000, 7);
         begin
            wait_size(3);
            bus.dout_ready = 1'b0;
            repeat (2) begin
               @(negedge clk);
               checks++;
               if (bus.din_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_data_din_ready: din_ready=%b required 0", bus.din_ready);
               end
            end
            @(posedge clk);
            #2;
            bus.dout_ready = 1'b1;
            wait_size(9);
            bus.dout_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               checks++;
               if ({bus.dout_valid, bus.dout, bus.parity_phase} !== 3'b111) begin
                  errors++;
                  $display("FAIL bp_parity_hold: valid/dout/pp=%b required 111",
                           {bus.dout_valid, bus.dout, bus.parity_phase});
               end
            end
            @(posedge clk);
            #2;
            bus.dout_ready = 1'b1;
         end
      join
      wait_idle("backpressure");
      checks++;
      if (q_bit.size() !== 15 || pack(q_bit) !== 32'h0000_40E8) begin
         errors++;
         $display("FAIL bp_codeword: n=%0d bits=%h required n=15 bits=000040e8",
                  q_bit.size(), pack(q_bit));
      end
   endtask

   task automatic test_init_abort();
      clear_q();
      send_bits(15'b1000, 4);
      bus.init      = 1'b1;
      bus.din       = 1'b1;
      bus.din_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.din_ready !== 1'b0) begin
         errors++;
         $display("FAIL init_din_ready: din_ready=%b required 0", bus.din_ready);
      end
      @(posedge clk);
      #1;
      bus.init      = 1'b0;
      bus.din_valid = 1'b0;
      checks++;
      if ({bus.dout_valid, bus.parity_phase, bus.busy} !== 3'b000) begin
         errors++;
         $display("FAIL init_clear: valid/pp/busy=%b required 000",
                  {bus.dout_valid, bus.parity_phase, bus.busy});
      end
      @(posedge clk);
      #1;
      test_single_one("after_init");
   endtask

   task automatic test_async_reset();
      clear_q();
      send_bits(15'b1000000, 7);
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (bus.parity_phase !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre_parity: parity_phase=%b required 1", bus.parity_phase);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.dout, bus.dout_valid, bus.parity_phase, bus.busy} !== 4'b0000) begin
         errors++;
         $display("FAIL areset_immediate: dout/valid/pp/busy=%b required 0000",
                  {bus.dout, bus.dout_valid, bus.parity_phase, bus.busy});
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      test_single_one("after_reset");
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      cyc            = 0;
      reset_n        = 1'b0;
      bus.init       = 1'b0;
      bus.din        = 1'b0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b1;
      test_reset();
      test_all_zero();
      test_single_one("single_one");
      test_back_to_back();
      test_backpressure();
      test_init_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
